// File: rtl/seq_detect_pkg.sv
// Shared constants and types for the programmable serial pattern detector.
package seq_detect_pkg;

    // Largest pattern length the detector family is built for.
    localparam int SEQ_MAX_LEN_LIMIT = 16;

    // Pattern and length loaded by reset.
    localparam logic [SEQ_MAX_LEN_LIMIT-1:0] SEQ_DEF_PATTERN = 16'b1010;
    localparam int                           SEQ_DEF_LEN     = 4;

    // Detection mode after a full match.
    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } mode_e;

    // A pattern must be at least two bits and must fit in the pattern register.
    function automatic logic len_illegal(input int len, input int max_len);
        return (len < 2) || (len > max_len);
    endfunction

endpackage

// File: rtl/seq_prefix_next.sv
// Combinational next-state for the detector: given the recent bit history
// (newest bit in bit 0), the active pattern and length, and the current
// matched-prefix length, returns the longest suffix of the history that is a
// proper prefix of the pattern, plus a flag when the whole pattern matched.
// The candidate length is capped at state+1 so that bits older than the
// current partial match (e.g. from before a clear) never contribute.
module seq_prefix_next #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] hist_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   state_i,
    output logic [LEN_W-1:0]   next_o,
    output logic               full_o
);

    logic [LEN_W-1:0] lim;
    logic [MAX_LEN:1] ok;

    assign lim = state_i + LEN_W'(1);

    // One comparator per candidate prefix length gi. The pattern's first gi
    // bits are pattern[len-1 : len-gi]; shifting right by len-gi aligns them
    // with the newest gi history bits.
    for (genvar gi = 1; gi <= MAX_LEN; gi++) begin : g_cand
        localparam logic [MAX_LEN-1:0] MASK = {MAX_LEN{1'b1}} >> (MAX_LEN - gi);
        logic [MAX_LEN-1:0] pshift;
        assign pshift = pattern_i >> (len_i - LEN_W'(gi));
        assign ok[gi] = (LEN_W'(gi) <= len_i) && (LEN_W'(gi) <= lim) &&
                        (((hist_i ^ pshift) & MASK) == '0);
    end

    // Pick the longest proper-prefix candidate; a full-length hit is the match.
    always_comb begin
        next_o = '0;
        full_o = 1'b0;
        for (int j = 1; j <= MAX_LEN; j++) begin
            if (ok[j]) begin
                if (LEN_W'(j) == len_i) begin
                    full_o = 1'b1;
                end else begin
                    next_o = LEN_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap control, registered
// Moore match flag and a saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                           MAX_LEN     = 8,
    parameter int                           CNT_W       = 8,
    parameter logic [SEQ_MAX_LEN_LIMIT-1:0] DEF_PATTERN = SEQ_DEF_PATTERN,
    parameter int                           DEF_LEN     = SEQ_DEF_LEN,
    parameter int                           LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   state,
    output logic               cfg_err
);

    // Active configuration.
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    mode_e              mode_q, mode_d;
    logic               err_q, err_d;

    // Detection state. Only MAX_LEN-1 past bits are kept: the matched prefix
    // never exceeds len-1, so the new bit plus these covers any candidate.
    logic [LEN_W-1:0]   state_q, state_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   pfx_next;
    logic               pfx_full;

    assign hist_shift = {hist_q, in_bit};

    seq_prefix_next #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_prefix (
        .hist_i    (hist_shift),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .state_i   (state_q),
        .next_o    (pfx_next),
        .full_o    (pfx_full)
    );

    // Register all state; reset restores the default configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= DEF_PATTERN[MAX_LEN-1:0];
            len_q   <= LEN_W'(DEF_LEN);
            mode_q  <= MODE_OVERLAP;
            err_q   <= 1'b0;
            state_q <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            hist_q  <= '0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
        end
    end

    // Next state: configuration load wins over data; match is a one-cycle pulse.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        mode_d  = mode_q;
        err_d   = err_q;
        state_d = state_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            mode_d  = mode_e'(cfg_overlap);
            err_d   = len_illegal(int'(cfg_len), MAX_LEN);
            state_d = '0;
            cnt_d   = '0;
            hist_d  = '0;
        end else if (in_valid && !err_q) begin
            hist_d = hist_shift[MAX_LEN-2:0];
            if (pfx_full) begin
                match_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = (mode_q == MODE_OVERLAP) ? pfx_next : '0;
            end else begin
                state_d = pfx_next;
            end
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign state       = state_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       match;
    logic [1:0] match_count;
    logic [3:0] state;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    seq_detect_prog #(
        .MAX_LEN (8),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (match),
        .match_count (match_count),
        .state       (state),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reset is asserted together with a bad cfg_load and a valid bit to show it wins.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cfg_load = 1'b1; cfg_len = 4'd0; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bit_in(input logic b, input int es, input logic em, input string tag);
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b1; in_bit = b;
        @(posedge clk); #1;
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_match"}, 32'(match), 32'(em));
        $display("step %s bit=%0d state=%0d match=%0d count=%0d", tag, b, state, match, match_count);
    endtask

    task automatic idle(input int es, input string tag);
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_match"}, 32'(match), 32'(0));
    endtask

    initial begin
        // Reset values (reset beat a simultaneous len-0 load).
        do_reset();
        chk("rst_match", 32'(match), 32'(0));
        chk("rst_count", 32'(match_count), 32'(0));
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_err",   32'(cfg_err), 32'(0));

        // Default 1010 overlapping: 1,0,1,0,1,0.
        bit_in(1, 1, 0, "d1"); bit_in(0, 2, 0, "d2"); bit_in(1, 3, 0, "d3");
        bit_in(0, 2, 1, "d4"); bit_in(1, 3, 0, "d5"); bit_in(0, 2, 1, "d6");
        chk("d_count", 32'(match_count), 32'(2));

        // Mismatch fallback: 1011 against 1010 -> 1.
        do_reset();
        bit_in(1, 1, 0, "f1"); bit_in(0, 2, 0, "f2"); bit_in(1, 3, 0, "f3");
        bit_in(1, 1, 0, "f4");

        // Idle gaps between accepted bits.
        do_reset();
        bit_in(1, 1, 0, "g1"); idle(1, "g1i"); idle(1, "g1i"); idle(1, "g1i");
        bit_in(0, 2, 0, "g2"); idle(2, "g2i"); idle(2, "g2i"); idle(2, "g2i");
        bit_in(1, 3, 0, "g3"); idle(3, "g3i"); idle(3, "g3i"); idle(3, "g3i");
        bit_in(0, 2, 1, "g4"); idle(2, "g4i");
        chk("g_count", 32'(match_count), 32'(1));

        // Non-overlapping 1010; junk above len must be ignored.
        load(8'b1111_1010, 4'd4, 1'b0);
        chk("n_load_count", 32'(match_count), 32'(0));
        chk("n_load_state", 32'(state), 32'(0));
        chk("n_load_err",   32'(cfg_err), 32'(0));
        bit_in(1, 1, 0, "n1"); bit_in(0, 2, 0, "n2"); bit_in(1, 3, 0, "n3");
        bit_in(0, 0, 1, "n4"); bit_in(1, 1, 0, "n5"); bit_in(0, 2, 0, "n6");
        bit_in(1, 3, 0, "n7"); bit_in(0, 0, 1, "n8");
        chk("n_count", 32'(match_count), 32'(2));

        // 11011011 overlapping (border 5), stream 11011011011 then 1,0.
        load(8'b1101_1011, 4'd8, 1'b1);
        bit_in(1, 1, 0, "b1");  bit_in(1, 2, 0, "b2");  bit_in(0, 3, 0, "b3");
        bit_in(1, 4, 0, "b4");  bit_in(1, 5, 0, "b5");  bit_in(0, 6, 0, "b6");
        bit_in(1, 7, 0, "b7");  bit_in(1, 5, 1, "b8");  bit_in(0, 6, 0, "b9");
        bit_in(1, 7, 0, "b10"); bit_in(1, 5, 1, "b11");
        chk("b_count", 32'(match_count), 32'(2));
        bit_in(1, 2, 0, "b12"); bit_in(0, 3, 0, "b13");

        // Saturation at 3 with CNT_W=2 over five matches.
        do_reset();
        bit_in(1, 1, 0, "s1"); bit_in(0, 2, 0, "s2");
        for (int k = 0; k < 5; k++) begin
            bit_in(1, 3, 0, "sa");
            bit_in(0, 2, 1, "sb");
            chk("s_count", 32'(match_count), 32'((k + 1 > 3) ? 3 : k + 1));
        end

        // Illegal lengths disable detection; a legal reload recovers.
        load(8'b0000_1010, 4'd0, 1'b1);
        chk("e0_err", 32'(cfg_err), 32'(1));
        bit_in(1, 0, 0, "e1"); bit_in(0, 0, 0, "e2"); bit_in(1, 0, 0, "e3"); bit_in(0, 0, 0, "e4");
        chk("e_count", 32'(match_count), 32'(0));
        load(8'b0000_0001, 4'd1, 1'b1);
        chk("e1_err", 32'(cfg_err), 32'(1));
        bit_in(1, 0, 0, "e5");
        load(8'b0000_1010, 4'd9, 1'b1);
        chk("e9_err", 32'(cfg_err), 32'(1));
        load(8'b0000_1010, 4'd4, 1'b1);
        chk("ok_err",   32'(cfg_err), 32'(0));
        chk("ok_count", 32'(match_count), 32'(0));
        bit_in(1, 1, 0, "r1"); bit_in(0, 2, 0, "r2"); bit_in(1, 3, 0, "r3"); bit_in(0, 2, 1, "r4");
        chk("r_count", 32'(match_count), 32'(1));

        // Reset mid-pattern discards history.
        do_reset();
        bit_in(1, 1, 0, "m1"); bit_in(0, 2, 0, "m2"); bit_in(1, 3, 0, "m3");
        do_reset();
        chk("m_rst_state", 32'(state), 32'(0));
        chk("m_rst_match", 32'(match), 32'(0));
        chk("m_rst_count", 32'(match_count), 32'(0));
        chk("m_rst_err",   32'(cfg_err), 32'(0));
        bit_in(0, 0, 0, "m4");
        chk("m_count", 32'(match_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
